in_channel: RTL and testbench



---
 rtl/xserial_pkg.sv | 23 ++
 rtl/rx_fifo.sv | 73 +++++++
 rtl/in_channel.sv | 167 ++++++++++++++++
 tb/tb_in_channel.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xserial_pkg.sv
// Shared XSerial definitions: frame geometry, flow-control message codes
// and the receive deserialiser state encoding.
package xserial_pkg;

  // Start + 12 payload + parity + stop.
  localparam int FRAME_BITS   = 15;
  localparam int PAYLOAD_BITS = 12;

  typedef logic [PAYLOAD_BITS-1:0] payload_t;

  // Payloads reserved for link-level flow control; never delivered upward.
  localparam payload_t HALT_MSG   = 12'h014;
  localparam payload_t RESUME_MSG = 12'h024;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT1
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO: power-of-two ring buffer with first-word fall-through head.
// A write while full is accepted only if the head is popped in the same cycle.
module rx_fifo
  import xserial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PAYLOAD_BITS,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push, pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign pop     = valid_o && rd_ready_i;
  assign push    = wr_en_i && (!full_o || pop);

  // Empty FIFO presents zero so the head reads as 0 straight out of reset.
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // Storage write port.
  // NOTE: the data array has no reset; valid_o masks stale contents, and
  // leaving it unreset lets synthesis map it onto plain registers/RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Next pointer/count values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/in_channel.sv
// XSerial port receiver: deserialises LSB-first 15-bit frames, checks
// parity/stop, consumes HALT/RESUME locally, buffers data frames and asks
// the paired transmitter for HALT/RESUME as the receive FIFO fills/drains.
module in_channel
  import xserial_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int HALT_LEVEL   = 2,
  parameter int RESUME_LEVEL = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_data,
  output logic [PAYLOAD_BITS-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    halted,
  output logic                    flow_req,
  output logic                    flow_halt,
  input  logic                    flow_ack,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALT_CNT   = CW'(HALT_LEVEL);
  localparam logic [CW-1:0] RESUME_CNT = CW'(RESUME_LEVEL);

  rx_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  payload_t   shift_q,   shift_d;
  logic       parity_q,  parity_d;
  logic       par_bad_q, par_bad_d;
  logic       halted_q,  halted_d;
  logic       want_halt_q, want_halt_d;
  logic       sent_halt_q, sent_halt_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q,  frame_err_d;
  logic       overflow_q,   overflow_d;

  logic          fifo_wr;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_BITS)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (shift_q),
    .rd_ready_i (frame_ready),
    .rd_data_o  (frame_data),
    .valid_o    (frame_valid),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign fifo_pop = frame_valid && frame_ready;

  // Deserialiser next state, frame evaluation and error pulse generation.
  // NOTE: every signal gets its default first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    par_bad_d    = par_bad_q;
    halted_d     = halted_q;
    fifo_wr      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!in_data) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          parity_d  = 1'b0;
        end
      end
      DATA: begin
        shift_d   = {in_data, shift_q[PAYLOAD_BITS-1:1]};
        parity_d  = parity_q ^ in_data;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(PAYLOAD_BITS - 1)) state_d = PARITY;
      end
      PARITY: begin
        par_bad_d = in_data ^ parity_q;
        state_d   = STOP;
      end
      STOP: begin
        if (!in_data) begin
          // A bad stop bit outranks a parity error; wait for the line to
          // go high so a stuck-low line is not read as a new start bit.
          frame_err_d = 1'b1;
          state_d     = WAIT1;
        end else begin
          state_d = IDLE;
          if (par_bad_q)                  parity_err_d = 1'b1;
          else if (shift_q == HALT_MSG)   halted_d     = 1'b1;
          else if (shift_q == RESUME_MSG) halted_d     = 1'b0;
          else                            fifo_wr      = 1'b1;
        end
      end
      WAIT1: begin
        if (in_data) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow: a data frame arrives with no room and no pop to make room.
  assign overflow_d = fifo_wr && fifo_full && !fifo_pop;

  // Flow-control intent with hysteresis between the two levels, and the
  // record of which message the transmitter last accepted.
  always_comb begin
    want_halt_d = want_halt_q;
    sent_halt_d = sent_halt_q;
    if (fifo_count >= HALT_CNT)        want_halt_d = 1'b1;
    else if (fifo_count <= RESUME_CNT) want_halt_d = 1'b0;
    if (flow_ack) sent_halt_d = want_halt_q;
  end

  assign flow_req   = (want_halt_q != sent_halt_q);
  assign flow_halt  = want_halt_q;
  assign halted     = halted_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

  // Receiver state register; reset discards any partially received frame.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      par_bad_q    <= 1'b0;
      halted_q     <= 1'b0;
      want_halt_q  <= 1'b0;
      sent_halt_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      par_bad_q    <= par_bad_d;
      halted_q     <= halted_d;
      want_halt_q  <= want_halt_d;
      sent_halt_q  <= sent_halt_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_in_channel.sv
// Bench for in_channel: table of single-frame vectors, hand-written
// multi-cycle sequences and randomized traffic, all compared every cycle
// against a frame-level reference model kept here.
module tb_in_channel;
  import xserial_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HLEVEL = 2;
  localparam int RLEVEL = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_data = 1'b1;
  logic        frame_ready = 1'b0;
  logic        flow_ack = 1'b0;
  logic [11:0] frame_data;
  logic        frame_valid, halted, flow_req, flow_halt;
  logic        parity_err, frame_err, overflow;

  always #5 clock = ~clock;

  in_channel #(
    .FIFO_DEPTH   (DEPTH),
    .HALT_LEVEL   (HLEVEL),
    .RESUME_LEVEL (RLEVEL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .halted      (halted),
    .flow_req    (flow_req),
    .flow_halt   (flow_halt),
    .flow_ack    (flow_ack),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [11:0] m_q[$];
  bit          m_halted, m_want, m_sent, m_pe, m_fe, m_ov;
  int          m_phase;      // -1 waiting for start, -2 waiting for a 1, 0..13 bit index
  logic [13:0] m_bits;       // payload[0..11], parity, stop

  task automatic model_reset();
    m_q.delete();
    m_halted = 0; m_want = 0; m_sent = 0;
    m_pe = 0; m_fe = 0; m_ov = 0;
    m_phase = -1;
    m_bits = '0;
  endtask

  // One rising edge of the link, applied to the model with the pre-edge state.
  task automatic model_edge(input bit din, input bit rdy, input bit ack);
    int          cnt;
    bit          pop, want_old, wr;
    logic [11:0] pl;
    cnt = m_q.size();
    pop = (cnt > 0) && rdy;
    want_old = m_want;
    wr = 0;
    pl = '0;
    m_pe = 0; m_fe = 0; m_ov = 0;
    if (m_phase == -2) begin
      if (din) m_phase = -1;
    end else if (m_phase == -1) begin
      if (!din) m_phase = 0;
    end else begin
      m_bits[m_phase] = din;
      if (m_phase == 13) begin
        pl = m_bits[11:0];
        if (!m_bits[13]) begin
          m_fe = 1;
          m_phase = -2;
        end else begin
          m_phase = -1;
          if (m_bits[12] != ^pl)    m_pe = 1;
          else if (pl == 12'h014)   m_halted = 1;
          else if (pl == 12'h024)   m_halted = 0;
          else                      wr = 1;
        end
      end else begin
        m_phase++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      if (cnt == DEPTH && !pop) m_ov = 1;
      else m_q.push_back(pl);
    end
    if (cnt >= HLEVEL)      m_want = 1;
    else if (cnt <= RLEVEL) m_want = 0;
    if (ack) m_sent = want_old;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [11:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 12'h000;
    check("frame_valid", {31'd0, frame_valid}, {31'd0, m_q.size() > 0});
    check("frame_data",  {20'd0, frame_data},  {20'd0, hd});
    check("halted",      {31'd0, halted},      {31'd0, m_halted});
    check("flow_req",    {31'd0, flow_req},    {31'd0, m_want != m_sent});
    check("flow_halt",   {31'd0, flow_halt},   {31'd0, m_want});
    check("parity_err",  {31'd0, parity_err},  {31'd0, m_pe});
    check("frame_err",   {31'd0, frame_err},   {31'd0, m_fe});
    check("overflow",    {31'd0, overflow},    {31'd0, m_ov});
  endtask

  // Drive one bit period, clock it, update the model and compare.
  task automatic cycle(input bit din, input bit rdy, input bit ack);
    in_data = din; frame_ready = rdy; flow_ack = ack;
    @(posedge clock);
    model_edge(din, rdy, ack);
    #1;
    compare_all();
  endtask

  // Random-mode helpers: ready mostly low, ack only while a request is pending.
  function automatic bit rnd_rdy();
    return ($urandom_range(0, 3) == 0);
  endfunction
  function automatic bit rnd_ack();
    return (m_want != m_sent) && ($urandom_range(0, 2) == 0);
  endfunction

  // mode 0: ready low throughout; 1: ready high only on the stop bit;
  // 2: random ready/ack every bit.
  task automatic send(input logic [11:0] pl, input bit pflip, input bit stopb, input int mode);
    bit rdy, ack;
    for (int i = 0; i < FRAME_BITS; i++) begin
      bit b;
      if (i == 0)       b = 1'b0;
      else if (i <= 12) b = pl[i-1];
      else if (i == 13) b = (^pl) ^ pflip;
      else              b = stopb;
      rdy = (mode == 2) ? rnd_rdy() : ((mode == 1) && (i == 14));
      ack = (mode == 2) ? rnd_ack() : 1'b0;
      cycle(b, rdy, ack);
    end
  endtask

  typedef struct {
    logic [11:0] payload;
    bit          pflip;
    bit          stopb;
    bit          exp_valid;
    logic [11:0] exp_data;
    bit          exp_pe;
    bit          exp_fe;
    bit          exp_halted;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // payload  pflip stop valid data    pe fe halted
    tbl[0] = '{12'hA5C, 0, 1, 1, 12'hA5C, 0, 0, 0};
    tbl[1] = '{12'hA5C, 1, 1, 0, 12'h000, 1, 0, 0};
    tbl[2] = '{12'hA5C, 0, 0, 0, 12'h000, 0, 1, 0};
    tbl[3] = '{12'hA5C, 1, 0, 0, 12'h000, 0, 1, 0};
    tbl[4] = '{12'h014, 0, 1, 0, 12'h000, 0, 0, 1};
    tbl[5] = '{12'h024, 0, 1, 0, 12'h000, 0, 0, 0};
    tbl[6] = '{12'h014, 1, 1, 0, 12'h000, 1, 0, 0};
    tbl[7] = '{12'hFFF, 0, 1, 1, 12'hFFF, 0, 0, 0};

    // ---- power-on reset ----
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_data",  {20'd0, frame_data},  32'd0);
    check("rst_flow",  {30'd0, flow_req, flow_halt}, 32'd0);
    reset = 1'b1;
    repeat (2) cycle(1, 0, 0);

    // ---- reset mid-frame ----
    send(12'h3C3, 0, 1, 0);
    cycle(1, 0, 0);
    check("pre_rst_valid", {31'd0, frame_valid}, 32'd1);
    cycle(0, 0, 0);                        // start bit of a frame that is cut off
    for (int i = 0; i < 5; i++) cycle(i[0], 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", {31'd0, frame_valid}, 32'd0);
    check("midrst_data",  {20'd0, frame_data},  32'd0);
    check("midrst_halt",  {31'd0, halted},      32'd0);
    check("midrst_errs",  {29'd0, parity_err, frame_err, overflow}, 32'd0);
    // The rest of the interrupted frame passes while reset is held.
    for (int i = 0; i < 9; i++) begin
      in_data = i[0];
      @(posedge clock);
    end
    #3 reset = 1'b1;
    in_data = 1'b1;
    repeat (4) cycle(1, 0, 0);
    check("post_rst_empty", {31'd0, frame_valid}, 32'd0);

    // ---- table-driven single frames ----
    foreach (tbl[k]) begin
      send(tbl[k].payload, tbl[k].pflip, tbl[k].stopb, 0);
      check("tbl_valid",  {31'd0, frame_valid}, {31'd0, tbl[k].exp_valid});
      check("tbl_data",   {20'd0, frame_data},  {20'd0, tbl[k].exp_data});
      check("tbl_perr",   {31'd0, parity_err},  {31'd0, tbl[k].exp_pe});
      check("tbl_ferr",   {31'd0, frame_err},   {31'd0, tbl[k].exp_fe});
      check("tbl_halted", {31'd0, halted},      {31'd0, tbl[k].exp_halted});
      if (!tbl[k].stopb) begin
        repeat (5) cycle(0, 0, 0);         // stuck-low line must not start a frame
        check("tbl_nostart", {31'd0, frame_valid}, 32'd0);
      end
      cycle(1, 0, 0);
      if (tbl[k].exp_valid) begin
        cycle(1, 1, 0);
        check("tbl_popped", {31'd0, frame_valid}, 32'd0);
      end
      cycle(1, 0, 0);
    end

    // ---- flow control and overflow, consumer stalled ----
    send(12'h111, 0, 1, 0); cycle(1, 0, 0);
    send(12'h222, 0, 1, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    check("fc_req_halt",  {31'd0, flow_req},  32'd1);
    check("fc_halt_bit",  {31'd0, flow_halt}, 32'd1);
    cycle(1, 0, 1);
    check("fc_req_acked", {31'd0, flow_req},  32'd0);
    send(12'h333, 0, 1, 0); cycle(1, 0, 0);
    send(12'h444, 0, 1, 0); cycle(1, 0, 0);
    send(12'h555, 0, 1, 0);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    cycle(1, 0, 0);
    check("ovf_single", {31'd0, overflow}, 32'd0);
    check("ovf_head",   {20'd0, frame_data}, 32'h111);
    cycle(1, 1, 0); check("pop_2", {20'd0, frame_data}, 32'h222);
    cycle(1, 1, 0); check("pop_3", {20'd0, frame_data}, 32'h333);
    cycle(1, 1, 0); check("pop_4", {20'd0, frame_data}, 32'h444);
    cycle(1, 0, 0); cycle(1, 0, 0);
    check("fc_req_resume", {31'd0, flow_req},  32'd1);
    check("fc_resume_bit", {31'd0, flow_halt}, 32'd0);
    cycle(1, 0, 1);
    check("fc_resume_acked", {31'd0, flow_req}, 32'd0);
    cycle(1, 1, 0);
    repeat (2) cycle(1, 0, 1);

    // ---- full FIFO, pop in the same cycle as a good stop bit ----
    for (int i = 1; i <= 4; i++) begin
      send(12'h600 + 12'(i), 0, 1, 0);
      cycle(1, 0, 1);
    end
    send(12'h605, 0, 1, 1);
    check("simul_noovf", {31'd0, overflow},   32'd0);
    check("simul_head",  {20'd0, frame_data}, 32'h602);
    for (int i = 2; i <= 5; i++) begin
      check("simul_order", {20'd0, frame_data}, 32'h600 + i);
      cycle(1, 1, 0);
    end
    check("simul_drained", {31'd0, frame_valid}, 32'd0);
    repeat (3) cycle(1, 0, 1);

    // ---- HALT wanted, then withdrawn before any ack ----
    send(12'h701, 0, 1, 0); cycle(1, 0, 0);
    send(12'h702, 0, 1, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    check("retract_req", {31'd0, flow_req}, 32'd1);
    cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    check("retract_drop", {31'd0, flow_req}, 32'd0);
    cycle(1, 1, 0);
    repeat (2) cycle(1, 0, 0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 250; n++) begin
      logic [11:0] pl;
      int sel;
      bit pflip, stopb;
      sel = $urandom_range(0, 7);
      pl = (sel == 0) ? 12'h014 : (sel == 1) ? 12'h024 : 12'($urandom);
      pflip = ($urandom_range(0, 9) == 0);
      stopb = ($urandom_range(0, 11) != 0);
      send(pl, pflip, stopb, 2);
      if (!stopb) begin
        int lows;
        lows = $urandom_range(0, 4);
        for (int j = 0; j < lows; j++) cycle(0, rnd_rdy(), rnd_ack());
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) cycle(1, rnd_rdy(), rnd_ack());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
